// File: rtl/mem_display_scan_if.sv
// Handshake-free bundle between the BRAM sequencer, the display scanner and the board pins.
interface mem_display_scan_if;
    logic [15:0] dataOutA;
    logic [15:0] dataOutB;
    logic        displaySelect;
    logic        hold;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] shownWord;
    logic        updated;
    logic        valid;

    modport master (
        output dataOutA, dataOutB, displaySelect, hold,
        input  seg, an, shownWord, updated, valid
    );

    modport slave (
        input  dataOutA, dataOutB, displaySelect, hold,
        output seg, an, shownWord, updated, valid
    );
endinterface

// File: rtl/mem_display_scan.sv
// Captures a BRAM port word and scans it onto four active-low hex digits.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the top nonzero nibble.
module mem_display_scan #(
    parameter int REFRESH_DIV = 50000
) (
    input logic               clk,
    input logic               rst,
    mem_display_scan_if.slave bus
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} dig_t;

    dig_t          digit;
    logic [CW-1:0] div_cnt;
    logic [15:0]   word;
    logic [15:0]   capture;
    logic [3:0]    nibble;
    logic [3:0]    an_lit;
    logic          blank;
    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic          updated_q;
    logic          valid_q;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign capture = bus.displaySelect ? bus.dataOutB : bus.dataOutA;

    always_comb begin
        nibble = word[3:0];
        an_lit = 4'b1110;
        unique case (digit)
            DIG0: begin nibble = word[3:0];   an_lit = 4'b1110; end
            DIG1: begin nibble = word[7:4];   an_lit = 4'b1101; end
            DIG2: begin nibble = word[11:8];  an_lit = 4'b1011; end
            DIG3: begin nibble = word[15:12]; an_lit = 4'b0111; end
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        unique case (digit)
            DIG1:    blank = (word[15:4] == 12'h000);
            DIG2:    blank = (word[15:8] == 8'h00);
            DIG3:    blank = (word[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    // seg/an are built from the registered word and digit, so they trail both by one edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word      <= 16'h0000;
            valid_q   <= 1'b0;
            updated_q <= 1'b0;
            div_cnt   <= '0;
            digit     <= DIG0;
            an_q      <= 4'b1110;
            seg_q     <= 7'b1000000;
        end else begin
            if (!bus.hold) begin
                word      <= capture;
                valid_q   <= 1'b1;
                updated_q <= (capture != word);
            end else begin
                updated_q <= 1'b0;
            end

            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                digit   <= dig_t'(digit + 2'd1);
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            an_q  <= blank ? 4'b1111 : an_lit;
            seg_q <= hex7(nibble);
        end
    end

    assign bus.shownWord = word;
    assign bus.valid     = valid_q;
    assign bus.updated   = updated_q;
    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
endmodule

// File: tb/tb_mem_display_scan.sv
// Randomised scoreboard bench: two scanners (divide 4 and divide 1) share one input stream.
module tb_mem_display_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic        sel = 1'b0;
    logic        hold = 1'b0;

    int checks = 0;
    int errors = 0;

    mem_display_scan_if bus4 ();
    mem_display_scan_if bus1 ();

    assign bus4.dataOutA = a;
    assign bus4.dataOutB = b;
    assign bus4.displaySelect = sel;
    assign bus4.hold = hold;
    assign bus1.dataOutA = a;
    assign bus1.dataOutB = b;
    assign bus1.displaySelect = sel;
    assign bus1.hold = hold;

    mem_display_scan #(.REFRESH_DIV(4)) u4 (.clk(clk), .rst(rst), .bus(bus4));
    mem_display_scan #(.REFRESH_DIV(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic        valid;
        logic        upd;
        logic [3:0]  an4;
        logic [6:0]  seg4;
        logic [3:0]  an1;
        logic [6:0]  seg1;
    } exp_t;

    exp_t q[$];

    logic [6:0] segtab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    // Digit d of word w: which anode is low (if any) and the glyph for its nibble
    task automatic disp(input logic [15:0] w, input int d,
                        output logic [3:0] an, output logic [6:0] seg);
        logic lit;
        logic [15:0] upper;
        upper = w >> (4 * d);
        lit = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        lit = (d == 0) || (upper != 16'h0);
`endif
        an = lit ? ~(4'b0001 << d) : 4'b1111;
        seg = segtab[upper[3:0]];
    endtask

    logic [15:0] m_word;
    logic        m_valid;
    int          m_edges;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_word = 16'h0;
            m_valid = 1'b0;
            m_edges = 0;
            q.delete();
        end else begin
            exp_t e;
            logic [15:0] nw;
            disp(m_word, (m_edges / 4) % 4, e.an4, e.seg4);
            disp(m_word, m_edges % 4, e.an1, e.seg1);
            nw = hold ? m_word : (sel ? b : a);
            e.upd = !hold && (nw != m_word);
            m_valid = m_valid || !hold;
            m_word = nw;
            e.word = nw;
            e.valid = m_valid;
            m_edges++;
            q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (!rst && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("shownWord", 32'(bus4.shownWord), 32'(e.word));
            chk("shownWord_d1", 32'(bus1.shownWord), 32'(e.word));
            chk("valid", 32'(bus4.valid), 32'(e.valid));
            chk("updated", 32'(bus4.updated), 32'(e.upd));
            chk("updated_d1", 32'(bus1.updated), 32'(e.upd));
            chk("an_d4", 32'(bus4.an), 32'(e.an4));
            chk("an_d1", 32'(bus1.an), 32'(e.an1));
            if (e.an4 != 4'b1111) chk("seg_d4", 32'(bus4.seg), 32'(e.seg4));
            if (e.an1 != 4'b1111) chk("seg_d1", 32'(bus1.seg), 32'(e.seg1));
        end
    end

    task automatic drive(input logic [15:0] na, input logic [15:0] nb,
                         input logic ns, input logic nh, input int n);
        a = na;
        b = nb;
        sel = ns;
        hold = nh;
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_an"}, 32'(bus4.an), 32'(4'b1110));
        chk({tag, "_seg"}, 32'(bus4.seg), 32'(7'b1000000));
        chk({tag, "_word"}, 32'(bus4.shownWord), 32'(16'h0));
        chk({tag, "_valid"}, 32'(bus4.valid), 32'(1'b0));
        chk({tag, "_updated"}, 32'(bus4.updated), 32'(1'b0));
        chk({tag, "_an_d1"}, 32'(bus1.an), 32'(4'b1110));
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? ra : 16'($urandom);
            drive(ra, rb, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 3), $urandom_range(1, 3));
        end
    endtask

    initial begin
        logic found;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        reset_checks("reset");
        rst = 1'b0;

        drive(16'h1234, 16'h0000, 1'b0, 1'b0, 20);
        drive(16'h0006, 16'h0000, 1'b0, 1'b1, 3);
        drive(16'h0006, 16'h0000, 1'b0, 1'b0, 3);
        drive(16'h0006, 16'h0005, 1'b1, 1'b0, 3);
        drive(16'h0005, 16'h0005, 1'b0, 1'b0, 2);
        drive(16'h0005, 16'h0005, 1'b1, 1'b0, 20);
        drive(16'h0000, 16'h0005, 1'b0, 1'b0, 20);

        random_run(300);

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = (bus4.an == 4'b0111);
        end
        chk("reach_an_0111", 32'(found), 32'(1'b1));
        #1 rst = 1'b1;
        #1 reset_checks("midscan");
        @(negedge clk);
        rst = 1'b0;

        drive(16'h00A0, 16'hBEEF, 1'b1, 1'b0, 20);
        random_run(150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
